// File: rtl/gfx_dma_pkg.sv
// Shared definitions for the blit sequencer: GfxDma register map, descriptor size,
// sequencer FSM states and error flag positions.
package gfx_dma_pkg;

  localparam int DESC_BYTES = 8;
  localparam int DESC_W     = DESC_BYTES * 8;

  localparam logic [2:0] REG_SRC_L  = 3'd0;
  localparam logic [2:0] REG_SRC_H  = 3'd1;
  localparam logic [2:0] REG_DST_L  = 3'd2;
  localparam logic [2:0] REG_DST_H  = 3'd3;
  localparam logic [2:0] REG_WIDTH  = 3'd4;
  localparam logic [2:0] REG_HEIGHT = 3'd5;
  localparam logic [2:0] REG_MASK   = 3'd6;
  localparam logic [2:0] REG_STATE  = 3'd7;

  localparam int ERR_OVF = 0;
  localparam int ERR_TMO = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WRITE = 3'd2,
    START = 3'd3,
    RUN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/gfx_desc_fifo.sv
// Descriptor FIFO, one 64-bit descriptor per entry, first-word fall-through head.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module gfx_desc_fifo
  import gfx_dma_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [DESC_W-1:0]   i_data,
  input  logic                i_pop,
  output logic [DESC_W-1:0]   o_head,
  output logic                o_full,
  output logic                o_empty,
  output logic                o_ovf,
  output logic [DEPTH_LOG2:0] o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DESC_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop   = i_pop && (r_level != '0);
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_full  = r_level[DEPTH_LOG2];
  assign o_empty = (r_level == '0);
  assign o_ovf   = i_push && !w_push;
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{DEPTH_LOG2{1'b0}}, w_push} - {{DEPTH_LOG2{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/gfx_blit_sequencer.sv
// Queues CPU-staged blit descriptors and replays them into the GfxDma registers.
// Optional o_irq (queue drained / start timeout) is enabled by GFX_BLIT_SEQ_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for a queued descriptor and an idle DMA
// REQ   | requesting the DMA register bus
// WRITE | streaming bytes 0..7 of the head descriptor while granted
// START | waiting for the DMA to report active, bounded by START_TIMEOUT
// RUN   | DMA busy with the blit
module gfx_blit_sequencer
  import gfx_dma_pkg::*;
#(
  parameter int DEPTH_LOG2    = 2,
  parameter int START_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [2:0]          i_wr_addr,
  input  logic [7:0]          i_wr_data,
  input  logic                i_commit,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_LOG2:0] o_level,
  output logic                o_bus_req,
  input  logic                i_bus_gnt,
  output logic                o_dma_ce_b,
  output logic                o_dma_we_b,
  output logic [2:0]          o_dma_addr,
  output logic [7:0]          o_dma_data,
  input  logic                i_dma_active,
  output logic                o_busy,
  output logic [1:0]          o_err,
  input  logic                i_err_clr
`ifdef GFX_BLIT_SEQ_IRQ_EN
  ,
  output logic                o_irq
`endif
);

  localparam int               TMO_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(START_TIMEOUT - 1);

  logic [7:0]        r_stage [DESC_BYTES];
  logic [DESC_W-1:0] w_stage_flat;
  logic [DESC_W-1:0] w_head;
  logic              w_empty;
  logic              w_ovf;

  seq_state_t        r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
  logic              w_pop, w_drive, w_tmo_evt;
  logic [1:0]        w_err_set;
  logic              r_bus_req, r_ce_b, r_we_b;
  logic [2:0]        r_addr;
  logic [7:0]        r_data;
  logic [1:0]        r_err;

  // Commit pushes the pre-edge staging image, so a same-cycle write lands afterwards.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DESC_BYTES; i++)
        r_stage[i] <= (i == int'(REG_MASK)) ? 8'hFF : 8'h00;
    end else if (i_wr_en) begin
      r_stage[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    w_stage_flat = '0;
    for (int i = 0; i < DESC_BYTES; i++)
      w_stage_flat[i*8 +: 8] = r_stage[i];
  end

  gfx_desc_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_commit),
    .i_data  (w_stage_flat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_ovf   (w_ovf),
    .o_level (o_level)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_pop       = 1'b0;
    w_drive     = 1'b0;
    w_tmo_evt   = 1'b0;
    case (r_state)
      IDLE:  if (!w_empty && !i_dma_active) w_state_nxt = REQ;
      REQ: begin
        if (i_dma_active) begin
          w_state_nxt = IDLE;
        end else if (i_bus_gnt) begin
          w_state_nxt = WRITE;
          w_cnt_nxt   = 3'd0;
        end
      end
      WRITE: begin
        if (i_bus_gnt) begin
          w_drive   = 1'b1;
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == REG_STATE) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
            w_tmo_nxt   = TMO_LOAD;
          end
        end
      end
      START: begin
        if (i_dma_active) begin
          w_state_nxt = RUN;
        end else if (r_tmo == '0) begin
          w_tmo_evt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo - 1'b1;
        end
      end
      RUN:     if (!i_dma_active) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Request stays up through the final STATE strobe and drops with it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bus_req <= 1'b0;
      r_ce_b    <= 1'b1;
      r_we_b    <= 1'b1;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_bus_req <= (w_state_nxt == REQ) || (w_state_nxt == WRITE) || w_drive;
      r_ce_b    <= !w_drive;
      r_we_b    <= !w_drive;
      if (w_drive) begin
        r_addr <= r_cnt;
        r_data <= w_head[{r_cnt, 3'b000} +: 8];
      end
    end
  end

  always_comb begin
    w_err_set          = 2'b00;
    w_err_set[ERR_OVF] = w_ovf;
    w_err_set[ERR_TMO] = w_tmo_evt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_err <= 2'b00;
    else       r_err <= (i_err_clr ? 2'b00 : r_err) | w_err_set;
  end

`ifdef GFX_BLIT_SEQ_IRQ_EN
  logic r_irq;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_irq <= 1'b0;
    else       r_irq <= ((r_state == RUN) && !i_dma_active && w_empty) || w_tmo_evt;
  end
  assign o_irq = r_irq;
`endif

  assign o_empty    = w_empty;
  assign o_busy     = (r_state != IDLE) || !w_empty;
  assign o_err      = r_err;
  assign o_bus_req  = r_bus_req;
  assign o_dma_ce_b = r_ce_b;
  assign o_dma_we_b = r_we_b;
  assign o_dma_addr = r_addr;
  assign o_dma_data = r_data;

endmodule

// File: tb/tb_gfx_blit_sequencer.sv
// Directed bench for gfx_blit_sequencer with a small GfxDma activity model.
module tb_gfx_blit_sequencer;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [2:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic       i_commit = 1'b0;
  logic       i_bus_gnt = 1'b1;
  logic       i_err_clr = 1'b0;
  logic       i_dma_active;
  logic       o_full, o_empty, o_bus_req, o_dma_ce_b, o_dma_we_b, o_busy;
  logic [2:0] o_level, o_dma_addr;
  logic [7:0] o_dma_data;
  logic [1:0] o_err;
`ifdef GFX_BLIT_SEQ_IRQ_EN
  logic       o_irq;
`endif

  gfx_blit_sequencer #(.DEPTH_LOG2(2), .START_TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_commit(i_commit), .o_full(o_full), .o_empty(o_empty),
    .o_level(o_level), .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt),
    .o_dma_ce_b(o_dma_ce_b), .o_dma_we_b(o_dma_we_b), .o_dma_addr(o_dma_addr),
    .o_dma_data(o_dma_data), .i_dma_active(i_dma_active), .o_busy(o_busy),
    .o_err(o_err), .i_err_clr(i_err_clr)
`ifdef GFX_BLIT_SEQ_IRQ_EN
    , .o_irq(o_irq)
`endif
  );

  always #20 i_clk = ~i_clk;

  // DMA model: goes active the cycle after the STATE write, for hold_cycles cycles.
  int act_cnt = 0;
  int hold_cycles = 5;
  bit never_active = 1'b0;
  bit force_active = 1'b0;
  always @(posedge i_clk) begin
    if (!o_dma_ce_b && !o_dma_we_b && o_dma_addr == 3'd7 && !never_active) act_cnt <= hold_cycles;
    else if (act_cnt > 0) act_cnt <= act_cnt - 1;
  end
  assign i_dma_active = force_active || (act_cnt != 0);

  logic [2:0] log_a [$];
  logic [7:0] log_d [$];
  int         log_c [$];
  int         cyc = 0;
  int         act_viol = 0;
  int         req_viol = 0;
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (!o_dma_ce_b && !o_dma_we_b) begin
      log_a.push_back(o_dma_addr);
      log_d.push_back(o_dma_data);
      log_c.push_back(cyc);
      if (i_dma_active) act_viol <= act_viol + 1;
    end
    if (o_bus_req && i_dma_active) req_viol <= req_viol + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic stage(input logic [2:0] a, input logic [7:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic commit();
    i_commit = 1'b1;
    @(negedge i_clk);
    i_commit = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input logic [2:0] a, input int max);
    int k = 0;
    while (!(!o_dma_ce_b && o_dma_addr == a) && k < max) begin
      @(negedge i_clk);
      k++;
    end
    chk_eq(tag, (k < max), 1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (o_busy && k < max) begin
      @(negedge i_clk);
      k++;
    end
    chk_eq(tag, (k < max), 1);
  endtask

  logic [7:0]  blit1 [8] = '{8'h10, 8'h02, 8'h50, 8'h40, 8'h03, 8'h07, 8'hFF, 8'h01};
  logic [7:0]  exp_b;
  logic [31:0] lv_trace;
  logic [2:0]  prev_lvl;
  int base, k, bad, av0, rv0, n;

  initial begin
    @(negedge i_clk);
    chk_eq("rst ce_b", o_dma_ce_b, 1);
    chk_eq("rst we_b", o_dma_we_b, 1);
    chk_eq("rst addr", o_dma_addr, 0);
    chk_eq("rst data", o_dma_data, 0);
    chk_eq("rst bus_req", o_bus_req, 0);
    chk_eq("rst err", o_err, 0);
    chk_eq("rst busy", o_busy, 0);
    chk_eq("rst empty", o_empty, 1);
    chk_eq("rst full", o_full, 0);
    chk_eq("rst level", o_level, 0);
    i_rst = 1'b0;
    tick(2);
    rv0 = req_viol;

    // Single blit; MASK byte left at its reset value 0xFF.
    for (int i = 0; i < 8; i++) if (i != 6) stage(3'(i), blit1[i]);
    base = log_a.size();
    hold_cycles = 5;
    commit();
    k = 0;
    while (!i_dma_active && k < 100) begin @(negedge i_clk); k++; end
    chk_eq("t1 active rise", (k < 100), 1);
    k = 0;
    while (i_dma_active && k < 100) begin @(negedge i_clk); k++; end
    chk_eq("t1 active fall", (k < 100), 1);
    chk_eq("t1 busy at active fall", o_busy, 1);
    @(negedge i_clk);
    chk_eq("t1 busy after", o_busy, 0);
    n = log_a.size() - base;
    chk_eq("t1 write count", n, 8);
    bad = 0;
    for (int i = 0; i < n && i < 8; i++) begin
      if (log_a[base+i] != 3'(i)) bad++;
      if (log_d[base+i] != blit1[i]) bad++;
      if (log_c[base+i] != log_c[base] + i) bad++;
    end
    chk_eq("t1 byte order/data/consecutive", bad, 0);

    // Back-to-back: commit+write in the same cycle pushes the old staging image.
    hold_cycles = 20;
    base = log_a.size();
    av0 = act_viol;
    i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 8'h21; i_commit = 1'b1;
    @(negedge i_clk);
    i_wr_data = 8'h22;
    @(negedge i_clk);
    i_wr_en = 1'b0;
    @(negedge i_clk);
    i_commit = 1'b0;
    chk_eq("t2 level 3", o_level, 3);
    lv_trace = 32'h3;
    prev_lvl = o_level;
    k = 0;
    while (o_busy && k < 1000) begin
      @(negedge i_clk);
      k++;
      if (o_level != prev_lvl) begin
        lv_trace = {lv_trace[27:0], 1'b0, o_level};
        prev_lvl = o_level;
      end
    end
    chk_eq("t2 drained", (k < 1000), 1);
    chk_eq("t2 level trace", lv_trace, 32'h3210);
    n = log_a.size() - base;
    chk_eq("t2 write count", n, 24);
    bad = 0;
    for (int i = 0; i < n; i++) if (log_a[base+i] != 3'(i % 8)) bad++;
    chk_eq("t2 addr sequence", bad, 0);
    if (n >= 24) begin
      chk_eq("t2 desc0 byte0", log_d[base], 8'h10);
      chk_eq("t2 desc1 byte0", log_d[base+8], 8'h21);
      chk_eq("t2 desc2 byte0", log_d[base+16], 8'h22);
    end
    chk_eq("t2 writes while active", act_viol - av0, 0);

    // Overflow with the DMA stalled active.
    hold_cycles = 3;
    force_active = 1'b1;
    tick(2);
    repeat (4) commit();
    chk_eq("t3 level 4", o_level, 4);
    chk_eq("t3 full", o_full, 1);
    chk_eq("t3 err before ovf", o_err, 0);
    commit();
    chk_eq("t3 err ovf", o_err, 2'b01);
    chk_eq("t3 level still 4", o_level, 4);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    chk_eq("t3 err cleared", o_err, 0);
    i_err_clr = 1'b1; i_commit = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0; i_commit = 1'b0;
    chk_eq("t3 err wins over clr", o_err, 2'b01);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    force_active = 1'b0;
    wait_strobe("t3 reach byte6", 3'd6, 100);
    chk_eq("t3 full before pop", o_full, 1);
    commit();
    chk_eq("t3 push with pop level", o_level, 4);
    chk_eq("t3 push with pop no err", o_err, 0);
    wait_idle("t3 drain", 800);
    chk_eq("t3 level empty", o_level, 0);

    // Grant loss after byte 3.
    base = log_a.size();
    commit();
    wait_strobe("t4 reach byte3", 3'd3, 50);
    i_bus_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk_eq("t4 strobe high in gap", o_dma_ce_b, 1);
    end
    chk_eq("t4 req held in gap", o_bus_req, 1);
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    chk_eq("t4 resume strobe", o_dma_ce_b, 0);
    chk_eq("t4 resume addr", o_dma_addr, 4);
    wait_idle("t4 done", 200);
    n = log_a.size() - base;
    chk_eq("t4 write count", n, 8);
    bad = 0;
    for (int i = 0; i < n && i < 8; i++) begin
      exp_b = (i == 0) ? 8'h22 : blit1[i];
      if (log_a[base+i] != 3'(i) || log_d[base+i] != exp_b) bad++;
    end
    chk_eq("t4 no repeat or skip", bad, 0);

    // Start timeout.
    never_active = 1'b1;
    base = log_a.size();
    commit();
    commit();
    wait_strobe("t5 first STATE write", 3'd7, 50);
    k = 0;
    while (!o_err[1] && k < 40) begin @(negedge i_clk); k++; end
    chk_eq("t5 timeout cycles", k, 15);
    wait_idle("t5 second blit done", 200);
    chk_eq("t5 write count", log_a.size() - base, 16);
    chk_eq("t5 err tmo", o_err, 2'b10);
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    chk_eq("t5 err cleared", o_err, 0);
    never_active = 1'b0;
    chk_eq("bus_req while active", req_viol - rv0, 0);

    // Reset mid-WRITE.
    hold_cycles = 5;
    commit();
    commit();
    wait_strobe("t6 reach byte5", 3'd5, 50);
    i_rst = 1'b1;
    #1;
    chk_eq("t6 ce_b async", o_dma_ce_b, 1);
    chk_eq("t6 we_b async", o_dma_we_b, 1);
    chk_eq("t6 bus_req", o_bus_req, 0);
    chk_eq("t6 empty", o_empty, 1);
    chk_eq("t6 level", o_level, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    base = log_a.size();
    tick(20);
    chk_eq("t6 busy after reset", o_busy, 0);
    chk_eq("t6 no writes after reset", log_a.size() - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
